col_dot_engine: RTL and testbench

- Downstream consumer of two column FIFOs (column a, column b) in the QR datapath.
- Pops one element from each FIFO in lockstep, VECTOR_LEN times per vector.
- Accumulates the signed fixed-point dot product and hands the result to the Gram-Schmidt projection stage over a valid/ready handshake.
- Free-running: begins the next vector as soon as the current result is accepted.

---
 rtl/qr_pkg.sv | 42 ++++
 rtl/fxp_mac.sv | 54 +++++
 rtl/col_dot_engine.sv | 90 +++++++++
 tb/tb_col_dot_engine.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/qr_pkg.sv
// qr_pkg: shared constants, FSM state type and the output shift/saturate
// helper for the QR datapath dot-product engine.
//   DEF_*       default element width, fractional bits and vector length
//   SAT_W       working width of sat_shift; must cover the accumulator width
//   state_e     col_dot_engine FSM states
//   sat_shift() arithmetic right shift by frac_b, then clamp to a signed
//               data_w-bit range (result is sign-extended to SAT_W bits)
package qr_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FRAC_BITS  = 16;
  localparam int DEF_VECTOR_LEN = 3;

  // Wide enough for 2*DATA_WIDTH + log2(VECTOR_LEN) + 1 at any sane size.
  localparam int SAT_W = 192;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } state_e;

  // Shift is arithmetic (floor), no rounding; then clamp to the
  // representable range of a data_w-bit signed value.
  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] acc,
    input int                      data_w,
    input int                      frac_b
  );
    logic signed [SAT_W-1:0] one, sh, hi, lo, res;
    one    = '0;
    one[0] = 1'b1;
    sh     = acc >>> frac_b;
    hi     = (one <<< (data_w - 1)) - one;
    lo     = -(one <<< (data_w - 1));
    if (sh > hi)      res = hi;
    else if (sh < lo) res = lo;
    else              res = sh;
    return res;
  endfunction

endpackage

// File: rtl/fxp_mac.sv
// fxp_mac: two-stage signed multiply-accumulate.
//   clk, reset  clock, synchronous active-high reset
//   en          capture a*b into the product register this edge
//   clr         zero the accumulator (takes priority over accumulation)
//   a, b        signed operands, DATA_WIDTH bits
//   acc         running sum of full-precision products, ACC_WIDTH bits
// A product captured on an en edge is folded into acc on the following edge.
module fxp_mac #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 67
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        clr,
  input  logic [DATA_WIDTH-1:0]       a,
  input  logic [DATA_WIDTH-1:0]       b,
  output logic signed [ACC_WIDTH-1:0] acc
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0]        prod_q, prod_d;
  logic                        prod_v_q, prod_v_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [PW-1:0]        a_x, b_x;

  always_comb begin
    // Sign-extend before multiplying so the truncated product is exact.
    a_x      = PW'($signed(a));
    b_x      = PW'($signed(b));
    prod_d   = prod_q;
    prod_v_d = en;
    if (en) prod_d = a_x * b_x;
    acc_d = acc_q;
    if (clr)           acc_d = '0;
    else if (prod_v_q) acc_d = acc_q + ACC_WIDTH'(prod_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q   <= '0;
      prod_v_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
      acc_q    <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/col_dot_engine.sv
// col_dot_engine: pops column a / column b FIFOs in lockstep VECTOR_LEN
// times, accumulates the signed fixed-point dot product and offers the
// shifted, saturated result over a valid/ready handshake.
//   clk, reset          clock, synchronous active-high reset
//   a_empty/a_data/a_rd column-a FIFO (head shown combinationally, rd pops)
//   b_empty/b_data/b_rd column-b FIFO
//   dot_out             saturated result, same Q format as inputs; 0 when idle
//   dot_valid/dot_ready result handshake
//   busy                vector partially consumed or result pending
module col_dot_engine
  import qr_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  parameter int VECTOR_LEN = DEF_VECTOR_LEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_empty,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_rd,
  input  logic                  b_empty,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_rd,
  output logic [DATA_WIDTH-1:0] dot_out,
  output logic                  dot_valid,
  input  logic                  dot_ready,
  output logic                  busy
);

  localparam int CNT_WIDTH = $clog2(VECTOR_LEN + 1);
  localparam int ACC_WIDTH = 2 * DATA_WIDTH + $clog2(VECTOR_LEN) + 1;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(VECTOR_LEN);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(VECTOR_LEN - 1);

  state_e                      state_q, state_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic                        pop, accept;
  logic signed [ACC_WIDTH-1:0] acc;

  always_comb begin
    pop       = (state_q == ACCUM) && !a_empty && !b_empty && (cnt_q < CNT_MAX);
    dot_valid = (state_q == OUT);
    accept    = dot_valid && dot_ready;
    state_d   = state_q;
    cnt_d     = cnt_q;

    if (accept)   cnt_d = '0;
    else if (pop) cnt_d = cnt_q + 1'b1;

    case (state_q)
      // Last pop of the vector: one more cycle lets its product land in acc.
      ACCUM:   if (pop && cnt_q == CNT_LAST) state_d = DRAIN;
      DRAIN:   state_d = OUT;
      OUT:     if (dot_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase

    a_rd    = pop;
    b_rd    = pop;
    busy    = (state_q != ACCUM) || (cnt_q != '0);
    dot_out = dot_valid ? DATA_WIDTH'(sat_shift(SAT_W'(acc), DATA_WIDTH, FRAC_BITS)) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Accumulator is cleared on handshake so the next vector starts from zero.
  fxp_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .en   (pop),
    .clr  (accept),
    .a    (a_data),
    .b    (b_data),
    .acc  (acc)
  );

endmodule

// File: tb/tb_col_dot_engine.sv
module tb_col_dot_engine;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          a_empty = 1'b1, b_empty = 1'b1;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_rd, b_rd, dot_valid, busy;
  logic          dot_ready = 1'b1;
  logic [DW-1:0] dot_out;

  logic [DW-1:0] a_fifo[$], b_fifo[$], exp_q[$];
  int   checks = 0, errors = 0, cyc = 0, last_pop = 0;
  logic rd_lat = 1'b0, valid_prev = 1'b0;

  always #5 clk = ~clk;

  col_dot_engine #(.DATA_WIDTH(DW), .FRAC_BITS(16), .VECTOR_LEN(3)) dut (
    .clk(clk), .reset(reset),
    .a_empty(a_empty), .a_data(a_data), .a_rd(a_rd),
    .b_empty(b_empty), .b_data(b_data), .b_rd(b_rd),
    .dot_out(dot_out), .dot_valid(dot_valid), .dot_ready(dot_ready), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score the handshake seen at the coming edge, apply FIFO pops,
  // refresh FIFO heads, then run per-cycle protocol checks at the negedge.
  task automatic tick();
    logic [DW-1:0] e;
    if (dot_valid === 1'b1 && dot_ready === 1'b1) begin
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("dot_out", dot_out, e);
      end
    end
    rd_lat = a_rd;
    @(posedge clk);
    if (rd_lat === 1'b1) begin
      if (a_fifo.size() != 0) void'(a_fifo.pop_front());
      if (b_fifo.size() != 0) void'(b_fifo.pop_front());
    end
    #1;
    a_empty = (a_fifo.size() == 0);
    b_empty = (b_fifo.size() == 0);
    a_data  = a_empty ? '0 : a_fifo[0];
    b_data  = b_empty ? '0 : b_fifo[0];
    @(negedge clk);
    cyc++;
    if (a_rd === 1'b1 || b_rd === 1'b1) begin
      check("rd_lockstep", 64'(b_rd), 64'(a_rd));
      check("rd_not_empty", 64'(a_empty | b_empty), 64'd0);
      last_pop = cyc;
    end
    if (dot_valid === 1'b1 && valid_prev !== 1'b1 && !reset)
      check("latency", 64'(cyc - last_pop), 64'd2);
    if (dot_valid === 1'b0) check("out_zero_idle", dot_out, '0);
    valid_prev = dot_valid;
  endtask

  task automatic push(input logic [DW-1:0] a0, a1, a2, b0, b1, b2, ex);
    a_fifo.push_back(a0); a_fifo.push_back(a1); a_fifo.push_back(a2);
    b_fifo.push_back(b0); b_fifo.push_back(b1); b_fifo.push_back(b2);
    exp_q.push_back(ex);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog expired");
  end

  initial begin
    int n;
    // Reset state
    reset = 1'b1;
    tick(); tick();
    check("rst_valid", 64'(dot_valid), 64'd0);
    check("rst_out",   dot_out, '0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_rd",    64'(a_rd), 64'd0);
    check("rst_cnt",   64'(dut.cnt_q), 64'd0);
    reset = 1'b0;
    tick();

    // Basic: three back-to-back pops, then 32.0
    push(32'h00010000, 32'h00020000, 32'h00030000,
         32'h00040000, 32'h00050000, 32'h00060000, 32'h00200000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("basic_pop", 64'(a_rd), 64'd1);
    end
    drain(20);

    // Sign and truncation
    push(32'h00008000, 32'hFFFFFFFF, 32'h0,
         32'hFFFF8000, 32'h00000001, 32'h0, 32'hFFFFBFFF);
    drain(20);
    push(32'h1, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0);
    drain(20);

    // Saturation both directions
    push(32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000,
         32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFFFFFF);
    drain(20);
    push(32'h80000000, 32'h80000000, 32'h80000000,
         32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h80000000);
    drain(20);

    // Stall: b runs dry after two elements
    a_fifo.push_back(32'h00010000); a_fifo.push_back(32'h00020000); a_fifo.push_back(32'h00030000);
    b_fifo.push_back(32'h00040000); b_fifo.push_back(32'h00050000);
    exp_q.push_back(32'h00200000);
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_ard", 64'(a_rd), 64'd0);
      check("stall_brd", 64'(b_rd), 64'd0);
      check("stall_cnt", 64'(dut.cnt_q), 64'd2);
      check("stall_busy", 64'(busy), 64'd1);
    end
    b_fifo.push_back(32'h00060000);
    drain(20);

    // Backpressure with two vectors queued
    dot_ready = 1'b0;
    push(32'h00010000, 32'h00020000, 32'h00030000,
         32'h00040000, 32'h00050000, 32'h00060000, 32'h00200000);
    push(32'h00010000, 32'h00010000, 32'h00010000,
         32'h00020000, 32'h00030000, 32'hFFFF0000, 32'h00040000);
    n = 0;
    while (dot_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("bp_valid_timeout", 64'(dot_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_valid_held", 64'(dot_valid), 64'd1);
      check("bp_out_stable", dot_out, 32'h00200000);
      check("bp_no_pop", 64'(a_rd), 64'd0);
    end
    dot_ready = 1'b1;
    tick();
    check("b2b_pop", 64'(a_rd), 64'd1);
    check("b2b_acc_clr", 64'(dut.u_mac.acc_q), 64'd0);
    drain(20);

    // Reset mid-vector
    a_fifo.push_back(32'h00010000); a_fifo.push_back(32'h00020000);
    b_fifo.push_back(32'h00040000); b_fifo.push_back(32'h00050000);
    tick(); tick(); tick();
    check("pre_rst_cnt", 64'(dut.cnt_q), 64'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", 64'(dot_valid), 64'd0);
    check("mid_rst_out",   dot_out, '0);
    check("mid_rst_busy",  64'(busy), 64'd0);
    check("mid_rst_cnt",   64'(dut.cnt_q), 64'd0);
    push(32'h00010000, 32'h00020000, 32'h00030000,
         32'h00040000, 32'h00050000, 32'h00060000, 32'h00200000);
    drain(20);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
